// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO pointer controller: default sizing,
// depth helper and status-bit indices used by the status register map.
package fifo_ctrl_pkg;

    localparam int FIFOCTRL_DEF_ADDR_W    = 2;
    localparam int FIFOCTRL_DEF_AFULL_LVL = 3;

    localparam int STS_FULL  = 0;
    localparam int STS_EMPTY = 1;
    localparam int STS_AFULL = 2;
    localparam int STS_OVF   = 3;
    localparam int STS_UDF   = 4;
    localparam int STS_W     = 5;

    function automatic int fifo_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/fifo_ptr_cnt.sv
// ADDR_W-bit wrapping pointer; the depth is a power of two, so the natural
// binary rollover gives the modulo-DEPTH wrap.
module fifo_ptr_cnt #(
    parameter int ADDR_W = 2
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              adv,
    output logic [ADDR_W-1:0] ptr
);

    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] ptr_reg;

    always_ff @(posedge CLK) begin
        if (rst) begin
            ptr_reg <= '0;
        end else if (adv) begin
            ptr_reg <= ptr_reg + PTR_ONE;
        end
    end

    assign ptr = ptr_reg;

endmodule

// File: rtl/fifo_pointer_ctrl.sv
// Read/write pointer, occupancy and status controller for the shared FIFOs.
// Sticky Overflow/Underflow flags exist only when FIFOCTRL_ERRFLAGS_EN is defined.
module fifo_pointer_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int ADDR_W    = FIFOCTRL_DEF_ADDR_W,
    parameter int AFULL_LVL = FIFOCTRL_DEF_AFULL_LVL
) (
    input  logic              CLK,
    input  logic              FIFOCTRL_RST,
    input  logic              FIFOCTRL_WrReq,
    input  logic              FIFOCTRL_WrHold,
    input  logic              FIFOCTRL_RdReq,
    input  logic              FIFOCTRL_RdHold,
    input  logic              FIFOCTRL_ErrClr,
    output logic [ADDR_W-1:0] FIFOCTRL_WrPtr,
    output logic [ADDR_W-1:0] FIFOCTRL_RdPtr,
    output logic [ADDR_W:0]   FIFOCTRL_Count,
    output logic              FIFOCTRL_Full,
    output logic              FIFOCTRL_Empty,
    output logic              FIFOCTRL_AlmostFull,
    output logic              FIFOCTRL_WrAccept,
    output logic              FIFOCTRL_RdAccept,
    output logic              FIFOCTRL_Overflow,
    output logic              FIFOCTRL_Underflow
);

    localparam int              DEPTH     = fifo_depth(ADDR_W);
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AFULL_CNT = (ADDR_W+1)'(AFULL_LVL);
    localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);

    logic [ADDR_W:0]   count_reg, count_next;
    logic [STS_W-1:0]  status_reg, status_next;
    logic              wr_try, rd_try;
    logic              wr_accept, rd_accept;
    logic [1:0]        ptr_adv;
    logic [ADDR_W-1:0] ptr_val [2];

    assign wr_try    = FIFOCTRL_WrReq & ~FIFOCTRL_WrHold;
    assign rd_try    = FIFOCTRL_RdReq & ~FIFOCTRL_RdHold;
    // Gated by the registered flags only, so Full admits a read and Empty a write.
    assign wr_accept = wr_try & ~status_reg[STS_FULL]  & ~FIFOCTRL_RST;
    assign rd_accept = rd_try & ~status_reg[STS_EMPTY] & ~FIFOCTRL_RST;
    assign ptr_adv   = {rd_accept, wr_accept};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ptr
            fifo_ptr_cnt #(
                .ADDR_W (ADDR_W)
            ) u_ptr (
                .CLK (CLK),
                .rst (FIFOCTRL_RST),
                .adv (ptr_adv[gi]),
                .ptr (ptr_val[gi])
            );
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        case ({wr_accept, rd_accept})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    always_comb begin
        status_next            = '0;
        status_next[STS_FULL]  = (count_next == DEPTH_CNT);
        status_next[STS_EMPTY] = (count_next == '0);
        status_next[STS_AFULL] = (count_next >= AFULL_CNT);
`ifdef FIFOCTRL_ERRFLAGS_EN
        // A new error in the same cycle as ErrClr keeps the flag set.
        status_next[STS_OVF] = (wr_try & status_reg[STS_FULL]) |
                               (status_reg[STS_OVF] & ~FIFOCTRL_ErrClr);
        status_next[STS_UDF] = (rd_try & status_reg[STS_EMPTY]) |
                               (status_reg[STS_UDF] & ~FIFOCTRL_ErrClr);
`endif
    end

`ifndef FIFOCTRL_ERRFLAGS_EN
    logic unused_errclr;
    assign unused_errclr = FIFOCTRL_ErrClr;
`endif

    always_ff @(posedge CLK) begin
        if (FIFOCTRL_RST) begin
            count_reg             <= '0;
            status_reg            <= '0;
            status_reg[STS_EMPTY] <= 1'b1;
        end else begin
            count_reg  <= count_next;
            status_reg <= status_next;
        end
    end

    assign FIFOCTRL_WrPtr      = ptr_val[0];
    assign FIFOCTRL_RdPtr      = ptr_val[1];
    assign FIFOCTRL_Count      = count_reg;
    assign FIFOCTRL_Full       = status_reg[STS_FULL];
    assign FIFOCTRL_Empty      = status_reg[STS_EMPTY];
    assign FIFOCTRL_AlmostFull = status_reg[STS_AFULL];
    assign FIFOCTRL_Overflow   = status_reg[STS_OVF];
    assign FIFOCTRL_Underflow  = status_reg[STS_UDF];
    assign FIFOCTRL_WrAccept   = wr_accept;
    assign FIFOCTRL_RdAccept   = rd_accept;

endmodule

// File: tb/tb_fifo_pointer_ctrl.sv
// Self-checking bench for fifo_pointer_ctrl: occupancy model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_fifo_pointer_ctrl;

    localparam int AW    = 2;
    localparam int AFL   = 3;
    localparam int DEPTH = 4;
`ifdef FIFOCTRL_ERRFLAGS_EN
    localparam int ERR_EN = 1;
`else
    localparam int ERR_EN = 0;
`endif

    logic          CLK = 1'b0;
    logic          rst = 1'b1, wr = 1'b0, wh = 1'b0, rd = 1'b0, rh = 1'b0, clr = 1'b0;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, empty, afull, wacc, racc, ovf, udf;

    int checks   = 0;
    int failures = 0;

    // Model state: what the registered outputs must show this cycle.
    int m_wp = 0, m_rp = 0, m_cnt = 0;
    int m_ovf = 0, m_udf = 0;
    bit m_valid = 1'b0;

    fifo_pointer_ctrl #(
        .ADDR_W    (AW),
        .AFULL_LVL (AFL)
    ) dut (
        .CLK                 (CLK),
        .FIFOCTRL_RST        (rst),
        .FIFOCTRL_WrReq      (wr),
        .FIFOCTRL_WrHold     (wh),
        .FIFOCTRL_RdReq      (rd),
        .FIFOCTRL_RdHold     (rh),
        .FIFOCTRL_ErrClr     (clr),
        .FIFOCTRL_WrPtr      (wr_ptr),
        .FIFOCTRL_RdPtr      (rd_ptr),
        .FIFOCTRL_Count      (count),
        .FIFOCTRL_Full       (full),
        .FIFOCTRL_Empty      (empty),
        .FIFOCTRL_AlmostFull (afull),
        .FIFOCTRL_WrAccept   (wacc),
        .FIFOCTRL_RdAccept   (racc),
        .FIFOCTRL_Overflow   (ovf),
        .FIFOCTRL_Underflow  (udf)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Pins both the model and the DUT to a hand-computed value.
    task automatic pin(input string name, input logic [31:0] act, input int mdl, input int lit);
        chk({name, "_model"}, 32'(mdl), lit);
        chk(name, act, lit);
    endtask

    always @(negedge CLK) begin
        int ewa, era;
        ewa = (!rst && wr && !wh && m_cnt != DEPTH) ? 1 : 0;
        era = (!rst && rd && !rh && m_cnt != 0) ? 1 : 0;
        if (m_valid) begin
            chk("wr_ptr",     32'(wr_ptr), m_wp);
            chk("rd_ptr",     32'(rd_ptr), m_rp);
            chk("count",      32'(count),  m_cnt);
            chk("full",       32'(full),   (m_cnt == DEPTH) ? 1 : 0);
            chk("empty",      32'(empty),  (m_cnt == 0) ? 1 : 0);
            chk("almost_full",32'(afull),  (m_cnt >= AFL) ? 1 : 0);
            chk("wr_accept",  32'(wacc),   ewa);
            chk("rd_accept",  32'(racc),   era);
            chk("overflow",   32'(ovf),    m_ovf);
            chk("underflow",  32'(udf),    m_udf);
        end
        if (rst) begin
            m_wp = 0; m_rp = 0; m_cnt = 0; m_ovf = 0; m_udf = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (ERR_EN != 0) begin
                if (wr && !wh && m_cnt == DEPTH) m_ovf = 1;
                else if (clr)                    m_ovf = 0;
                if (rd && !rh && m_cnt == 0)     m_udf = 1;
                else if (clr)                    m_udf = 0;
            end
            m_wp  = (m_wp + ewa) % DEPTH;
            m_rp  = (m_rp + era) % DEPTH;
            m_cnt = m_cnt + ewa - era;
        end
    end

    task automatic cyc(input bit r, input bit w, input bit w_h, input bit r_q, input bit r_h, input bit c);
        rst = r; wr = w; wh = w_h; rd = r_q; rh = r_h; clr = c;
        @(posedge CLK);
        #1;
        $display("txn rst=%0b wr=%0b wh=%0b rd=%0b rh=%0b clr=%0b -> cnt=%0d wp=%0d rp=%0d ovf=%0b udf=%0b",
                 r, w, w_h, r_q, r_h, c, count, wr_ptr, rd_ptr, ovf, udf);
    endtask

    initial begin
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        pin("rst_count", 32'(count), m_cnt, 0);
        pin("rst_empty", 32'(empty), (m_cnt == 0) ? 1 : 0, 1);

        // Fill from empty.
        for (int i = 1; i <= 4; i++) begin
            cyc(0, 1, 0, 0, 0, 0);
            pin("fill_wr_ptr", 32'(wr_ptr), m_wp, i % 4);
            if (i == 3) pin("fill_afull", 32'(afull), (m_cnt >= AFL) ? 1 : 0, 1);
        end
        pin("fill_count", 32'(count), m_cnt, 4);
        pin("fill_full",  32'(full),  (m_cnt == DEPTH) ? 1 : 0, 1);

        // Write into a full FIFO.
        cyc(0, 1, 0, 0, 0, 0);
        pin("ovf_wr_ptr", 32'(wr_ptr), m_wp, 0);
        pin("ovf_flag",   32'(ovf),    m_ovf, ERR_EN);

        // Full with both requests: only the read goes.
        cyc(0, 1, 0, 1, 0, 0);
        pin("fullrw_rd_ptr", 32'(rd_ptr), m_rp, 1);
        pin("fullrw_count",  32'(count),  m_cnt, 3);
        pin("fullrw_full",   32'(full),   (m_cnt == DEPTH) ? 1 : 0, 0);

        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0);
        pin("drain_count", 32'(count), m_cnt, 0);
        pin("drain_rd_ptr", 32'(rd_ptr), m_rp, 0);

        // Empty with both requests: only the write goes, then steady streaming.
        cyc(0, 1, 0, 1, 0, 0);
        pin("emptyrw_count", 32'(count), m_cnt, 1);
        pin("emptyrw_empty", 32'(empty), (m_cnt == 0) ? 1 : 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, 1, 0, 0);
        pin("stream_count",  32'(count),  m_cnt, 1);
        pin("stream_wr_ptr", 32'(wr_ptr), m_wp, 3);
        pin("stream_rd_ptr", 32'(rd_ptr), m_rp, 2);

        // Write held off while reads drain past empty.
        cyc(0, 1, 0, 0, 0, 0);
        pin("hold_pre_count", 32'(count), m_cnt, 2);
        cyc(0, 1, 1, 1, 0, 0);
        pin("hold_count1", 32'(count), m_cnt, 1);
        cyc(0, 1, 1, 1, 0, 0);
        pin("hold_count0", 32'(count), m_cnt, 0);
        pin("hold_udf_pre", 32'(udf), m_udf, 0);
        cyc(0, 1, 1, 1, 0, 0);
        pin("hold_count_stay", 32'(count), m_cnt, 0);
        pin("hold_wr_ptr", 32'(wr_ptr), m_wp, 0);
        pin("hold_udf", 32'(udf), m_udf, ERR_EN);

        // Error clear, set-wins, then reset mid-operation.
        cyc(0, 0, 0, 0, 0, 1);
        pin("clr_ovf", 32'(ovf), m_ovf, 0);
        pin("clr_udf", 32'(udf), m_udf, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 1);
        pin("setwins_ovf", 32'(ovf), m_ovf, ERR_EN);
        cyc(0, 0, 0, 0, 0, 1);
        pin("clr2_ovf", 32'(ovf), m_ovf, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        pin("prerst_count", 32'(count), m_cnt, 3);
        cyc(1, 1, 0, 0, 0, 0);
        pin("midrst_count",  32'(count),  m_cnt, 0);
        pin("midrst_wr_ptr", 32'(wr_ptr), m_wp, 0);
        pin("midrst_rd_ptr", 32'(rd_ptr), m_rp, 0);
        pin("midrst_ovf",    32'(ovf),    m_ovf, 0);
        chk("midrst_empty", 32'(empty), 1);
        chk("midrst_full",  32'(full),  0);
        chk("midrst_afull", 32'(afull), 0);

        // Random traffic with shifting write/read bias.
        for (int blk = 0; blk < 15; blk++) begin
            int wpct, rpct;
            wpct = $urandom_range(15, 85);
            rpct = $urandom_range(15, 85);
            for (int i = 0; i < 200; i++) begin
                cyc($urandom_range(0, 127) == 0,
                    $urandom_range(0, 99) < wpct,
                    $urandom_range(0, 9) == 0,
                    $urandom_range(0, 99) < rpct,
                    $urandom_range(0, 9) == 0,
                    $urandom_range(0, 15) == 0);
            end
        end
        cyc(0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_pointer_ctrl.md
# fifo_pointer_ctrl

Parametrised read/write pointer controller for the on-chip FIFOs between PLC cores and shared peripherals. Two wrapping pointers with per-side hold inputs, plus occupancy count, full/empty/almost-full flags and accept strobes. The FIFO RAM uses these outputs directly as its write enable, read enable and addresses.

## Interface
- ADDR_W, 2, pointer width; depth DEPTH = 2**ADDR_W (1..8 supported)
- AFULL_LVL, 3, AlmostFull asserts when Count >= AFULL_LVL (1..DEPTH)
- CLK  in  1  clock, all logic on rising edge
- FIFOCTRL_RST  in  1  reset, synchronous, active-high
- FIFOCTRL_WrReq  in  1  write request
- FIFOCTRL_WrHold  in  1  write inhibit; when 1, WrReq is ignored
- FIFOCTRL_RdReq  in  1  read request
- FIFOCTRL_RdHold  in  1  read inhibit; when 1, RdReq is ignored
- FIFOCTRL_ErrClr  in  1  clears sticky error flags (see Configuration)
- FIFOCTRL_WrPtr  out  ADDR_W  RAM write address
- FIFOCTRL_RdPtr  out  ADDR_W  RAM read address
- FIFOCTRL_Count  out  ADDR_W+1  occupancy, 0..DEPTH
- FIFOCTRL_Full / FIFOCTRL_Empty / FIFOCTRL_AlmostFull  out  1  registered status flags
- FIFOCTRL_WrAccept / FIFOCTRL_RdAccept  out  1  combinational accept strobes
- FIFOCTRL_Overflow / FIFOCTRL_Underflow  out  1  sticky error flags

## Operation
- WrAccept = WrReq & !WrHold & !Full.
- RdAccept = RdReq & !RdHold & !Empty.
- Full and Empty are the registered flags, never next-state values.
- WrAccept advances WrPtr by 1; RdAccept advances RdPtr by 1.
- Pointers wrap modulo DEPTH: DEPTH-1 goes to 0.
- Count update: +1 on write only, -1 on read only, unchanged on both or neither.
- Count never leaves 0..DEPTH.
- Full = (Count == DEPTH), Empty = (Count == 0), AlmostFull = (Count >= AFULL_LVL). All three are registered and computed from the next Count.
- Full with simultaneous WrReq and RdReq: only the read is accepted. Count becomes DEPTH-1 and Full drops next cycle.
- Empty with simultaneous WrReq and RdReq: only the write is accepted. Count becomes 1 and Empty drops next cycle.
- Hold has priority over Req on each side. Hold on one side does not affect the other side.
- Reset values: WrPtr=0, RdPtr=0, Count=0, Empty=1, Full=0, AlmostFull=0, Overflow=0, Underflow=0.
- While reset is high, the accept strobes read 0.
- Reset mid-operation discards all occupancy in the cycle reset is sampled. Any request in that cycle is dropped.

## Timing
- Accept strobes are combinational from inputs and registered flags. Zero latency, same cycle as the request.
- Pointers, Count and flags update on the edge that samples the accept. They are visible the following cycle (1-cycle latency).
- No combinational path from the Req inputs to WrPtr/RdPtr/Count/flags.
- Sustained one write and one read per cycle is supported at any occupancy except Full (read only) or Empty (write only).

## Configuration
- Macro: FIFOCTRL_ERRFLAGS_EN.
- Defined:
  - Overflow sets on (WrReq & !WrHold & Full).
  - Underflow sets on (RdReq & !RdHold & Empty).
  - Both flags stay set until reset or ErrClr.
  - If ErrClr and a new error occur in the same cycle, set wins.
  - Flags update one cycle after the offending request.
- Undefined:
  - Overflow and Underflow are tied to 0.
  - ErrClr is ignored.
  - Port list is unchanged in both builds.

## Structure
- Shared package fifo_ctrl_pkg holds:
  - depth helper function (2**ADDR_W)
  - default ADDR_W and AFULL_LVL constants
  - status-bit index constants (FULL, EMPTY, AFULL, OVF, UDF), shared with the status register map
- Sub-module fifo_ptr_cnt: ADDR_W-bit wrapping counter with synchronous reset and an advance input. It is instantiated twice, once for WrPtr and once for RdPtr.
- Count, flags and error logic live in the top module.

## Test plan
- Reset, then 4 writes with ADDR_W=2 -> WrPtr 1,2,3,0; Count 4; Full=1 the cycle after the 4th write; AlmostFull=1 after the 3rd write.
- Full, then WrReq=1 with no read -> WrAccept=0; WrPtr stays 0; Overflow=1 next cycle (macro defined) or 0 (undefined).
- Full, then WrReq=RdReq=1 -> only RdAccept=1; RdPtr 0->1; Count 4->3; Full=0 next cycle.
- Empty, then WrReq=RdReq=1 -> only WrAccept=1; Count 0->1; Empty=0 next cycle. Then both requests for 10 cycles -> Count stays 1 and both pointers wrap.
- WrReq=1 with WrHold=1 for 3 cycles, RdReq=1 concurrently at Count=2 -> no writes; Count 2->1->0 and stays 0; Empty=1; Underflow=1 on the 3rd read (macro defined).
- Reset asserted at Count=3 together with WrReq -> next cycle all outputs equal their reset values; ErrClr=1 clears a previously set Overflow.
